// File: rtl/clock_timekeeper.sv
// Time-of-day counter with editable time and alarm fields and a tick-counted alarm ring.
// All outputs come straight from registers; reset is synchronous and active-high.
module clock_timekeeper #(
    parameter int unsigned RING_LEN = 30
) (
    input  logic       m_clk,
    input  logic       m_reset,
    input  logic       tick,
    input  logic       m_load,
    input  logic       m_alarm,
    input  logic       inc_sec,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       alarm_en,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [5:0] al_sec,
    output logic [5:0] al_min,
    output logic [4:0] al_hour,
    output logic       ring
);

    localparam int unsigned CntW = (RING_LEN < 1) ? 1 : $clog2(RING_LEN + 1);

    logic [5:0]      r_sec, r_min, r_al_sec, r_al_min;
    logic [4:0]      r_hour, r_al_hour;
    logic            r_ring;
    logic [CntW-1:0] r_cnt;

    logic [5:0]      w_sec_d, w_min_d, w_al_sec_d, w_al_min_d;
    logic [4:0]      w_hour_d, w_al_hour_d;
    logic            w_ring_d;
    logic [CntW-1:0] w_cnt_d;

    logic            w_load_mode, w_aset_mode, w_advance, w_any_inc, w_match;
    logic [5:0]      w_adv_sec, w_adv_min;
    logic [4:0]      w_adv_hour;

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc24(input logic [4:0] v);
        return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    always_comb begin
        // Both mode bits high is decoded as plain clock mode.
        w_load_mode = m_load & ~m_alarm;
        w_aset_mode = m_alarm & ~m_load;
        w_advance   = tick & ~w_load_mode;
        w_any_inc   = inc_sec | inc_min | inc_hour;

        w_adv_sec  = inc60(r_sec);
        w_adv_min  = (r_sec == 6'd59) ? inc60(r_min) : r_min;
        w_adv_hour = ((r_sec == 6'd59) && (r_min == 6'd59)) ? inc24(r_hour) : r_hour;

        w_sec_d     = r_sec;
        w_min_d     = r_min;
        w_hour_d    = r_hour;
        w_al_sec_d  = r_al_sec;
        w_al_min_d  = r_al_min;
        w_al_hour_d = r_al_hour;
        w_ring_d    = r_ring;
        w_cnt_d     = r_cnt;

        if (w_load_mode) begin
            if (inc_sec)  w_sec_d  = inc60(r_sec);
            if (inc_min)  w_min_d  = inc60(r_min);
            if (inc_hour) w_hour_d = inc24(r_hour);
        end else if (w_advance) begin
            w_sec_d  = w_adv_sec;
            w_min_d  = w_adv_min;
            w_hour_d = w_adv_hour;
        end

        if (w_aset_mode) begin
            if (inc_sec)  w_al_sec_d  = inc60(r_al_sec);
            if (inc_min)  w_al_min_d  = inc60(r_al_min);
            if (inc_hour) w_al_hour_d = inc24(r_al_hour);
        end

        // Only a time-advancing tick can match; field edits never do.
        w_match = w_advance & alarm_en &
                  ({w_adv_hour, w_adv_min, w_adv_sec} == {r_al_hour, r_al_min, r_al_sec});

        if (w_any_inc || !alarm_en) begin
            w_ring_d = 1'b0;
            w_cnt_d  = '0;
        end else if (w_match) begin
            w_ring_d = 1'b1;
            w_cnt_d  = CntW'(RING_LEN);
        end else if (r_ring && tick) begin
            if (r_cnt <= CntW'(1)) begin
                w_ring_d = 1'b0;
                w_cnt_d  = '0;
            end else begin
                w_cnt_d = r_cnt - CntW'(1);
            end
        end
    end

    always_ff @(posedge m_clk) begin
        if (m_reset) begin
            r_sec     <= '0;
            r_min     <= '0;
            r_hour    <= '0;
            r_al_sec  <= '0;
            r_al_min  <= '0;
            r_al_hour <= '0;
            r_ring    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sec     <= w_sec_d;
            r_min     <= w_min_d;
            r_hour    <= w_hour_d;
            r_al_sec  <= w_al_sec_d;
            r_al_min  <= w_al_min_d;
            r_al_hour <= w_al_hour_d;
            r_ring    <= w_ring_d;
            r_cnt     <= w_cnt_d;
        end
    end

    assign sec     = r_sec;
    assign min     = r_min;
    assign hour    = r_hour;
    assign al_sec  = r_al_sec;
    assign al_min  = r_al_min;
    assign al_hour = r_al_hour;
    assign ring    = r_ring;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench for clock_timekeeper: reset, rollover, editing, alarm ring and cancel.
module tb_clock_timekeeper;

    logic       m_clk = 1'b0;
    logic       m_reset = 1'b1;
    logic       tick = 1'b0, m_load = 1'b0, m_alarm = 1'b0;
    logic       inc_sec = 1'b0, inc_min = 1'b0, inc_hour = 1'b0, alarm_en = 1'b0;
    logic [5:0] sec, min, al_sec, al_min;
    logic [4:0] hour, al_hour;
    logic       ring;
    logic [16:0] t_now, a_now;

    int n_vec = 0;
    int n_err = 0;

    clock_timekeeper #(.RING_LEN(30)) dut (
        .m_clk    (m_clk),
        .m_reset  (m_reset),
        .tick     (tick),
        .m_load   (m_load),
        .m_alarm  (m_alarm),
        .inc_sec  (inc_sec),
        .inc_min  (inc_min),
        .inc_hour (inc_hour),
        .alarm_en (alarm_en),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .al_sec   (al_sec),
        .al_min   (al_min),
        .al_hour  (al_hour),
        .ring     (ring)
    );

    always #5 m_clk = ~m_clk;

    assign t_now = {hour, min, sec};
    assign a_now = {al_hour, al_min, al_sec};

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic step();
        @(posedge m_clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Walk the time (load mode) or alarm (alarm-set mode) fields to a target with inc pulses.
    task automatic edit_to(input bit alarm_mode, input int h, input int m, input int s);
        logic [16:0] cur;
        m_load  = !alarm_mode;
        m_alarm = alarm_mode;
        for (int i = 0; i < 64; i++) begin
            cur      = alarm_mode ? a_now : t_now;
            inc_hour = (cur[16:12] != 5'(h));
            inc_min  = (cur[11:6] != 6'(m));
            inc_sec  = (cur[5:0] != 6'(s));
            if (!(inc_hour || inc_min || inc_sec)) break;
            step();
        end
        inc_hour = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
        m_load = 1'b0; m_alarm = 1'b0;
        cur = alarm_mode ? a_now : t_now;
        n_vec++;
        if (cur !== hms(h, m, s)) begin
            n_err++;
            $display("FAIL edit_to: got %h required %h", cur, hms(h, m, s));
        end
    endtask

    task automatic test_reset();
        step(); step();
        m_reset = 1'b0;
        n_vec++;
        if (t_now !== 17'h0 || a_now !== 17'h0 || ring !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: got t=%h a=%h ring=%b required 0/0/0", t_now, a_now, ring);
        end
        edit_to(0, 1, 2, 3);
        edit_to(1, 4, 5, 6);
        m_reset = 1'b1; m_load = 1'b1; tick = 1'b1; alarm_en = 1'b1;
        inc_sec = 1'b1; inc_min = 1'b1; inc_hour = 1'b1;
        step();
        m_reset = 1'b0; m_load = 1'b0; tick = 1'b0; alarm_en = 1'b0;
        inc_sec = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        n_vec++;
        if (t_now !== 17'h0) begin
            n_err++;
            $display("FAIL reset_time: got %h required 0", t_now);
        end
        n_vec++;
        if (a_now !== 17'h0 || ring !== 1'b0) begin
            n_err++;
            $display("FAIL reset_alarm: got a=%h ring=%b required 0/0", a_now, ring);
        end
    endtask

    task automatic test_rollover();
        logic [16:0] exp_t [3];
        exp_t[0] = hms(23, 59, 59);
        exp_t[1] = hms(0, 0, 0);
        exp_t[2] = hms(0, 0, 1);
        edit_to(0, 23, 59, 58);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            n_vec++;
            if (t_now !== exp_t[i]) begin
                n_err++;
                $display("FAIL rollover_%0d: got %h required %h", i, t_now, exp_t[i]);
            end
        end
    endtask

    task automatic test_load_isolation();
        edit_to(0, 0, 0, 59);
        m_load = 1'b1; tick = 1'b1; inc_sec = 1'b1;
        step();
        tick = 1'b0; inc_sec = 1'b0;
        n_vec++;
        if (t_now !== hms(0, 0, 0)) begin
            n_err++;
            $display("FAIL load_sec_wrap: got %h required %h", t_now, hms(0, 0, 0));
        end
        do_tick();
        n_vec++;
        if (t_now !== hms(0, 0, 0)) begin
            n_err++;
            $display("FAIL load_tick_frozen: got %h required %h", t_now, hms(0, 0, 0));
        end
        m_load = 1'b0;
        edit_to(0, 5, 59, 0);
        m_load = 1'b1; inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        n_vec++;
        if (t_now !== hms(5, 0, 0)) begin
            n_err++;
            $display("FAIL load_min_nocarry: got %h required %h", t_now, hms(5, 0, 0));
        end
        m_load = 1'b0;
        edit_to(0, 23, 59, 59);
        m_load = 1'b1; inc_sec = 1'b1; inc_min = 1'b1; inc_hour = 1'b1;
        step();
        inc_sec = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; m_load = 1'b0;
        n_vec++;
        if (t_now !== hms(0, 0, 0)) begin
            n_err++;
            $display("FAIL load_all_wrap: got %h required %h", t_now, hms(0, 0, 0));
        end
    endtask

    task automatic test_clock_ignores_inc();
        inc_sec = 1'b1; inc_hour = 1'b1;
        step();
        inc_sec = 1'b0; inc_hour = 1'b0;
        n_vec++;
        if (t_now !== hms(0, 0, 0) || a_now !== hms(4, 5, 6) && a_now !== 17'h0) begin
            n_err++;
            $display("FAIL clock_inc_ignored: got t=%h a=%h required t=%h", t_now, a_now,
                     hms(0, 0, 0));
        end
    endtask

    task automatic test_alarm_fire();
        edit_to(1, 0, 1, 0);
        edit_to(0, 0, 0, 59);
        alarm_en = 1'b1;
        do_tick();
        n_vec++;
        if (t_now !== hms(0, 1, 0) || ring !== 1'b1) begin
            n_err++;
            $display("FAIL fire_match: got t=%h ring=%b required t=%h ring=1", t_now, ring,
                     hms(0, 1, 0));
        end
        step();
        n_vec++;
        if (ring !== 1'b1) begin
            n_err++;
            $display("FAIL fire_hold_no_tick: got ring=%b required 1", ring);
        end
        for (int i = 1; i <= 30; i++) begin
            do_tick();
            n_vec++;
            if (ring !== (i < 30)) begin
                n_err++;
                $display("FAIL fire_count_%0d: got ring=%b required %b", i, ring, i < 30);
            end
        end
        n_vec++;
        if (t_now !== hms(0, 1, 30)) begin
            n_err++;
            $display("FAIL fire_time_after: got %h required %h", t_now, hms(0, 1, 30));
        end
        edit_to(0, 0, 0, 59);
        alarm_en = 1'b0;
        do_tick();
        n_vec++;
        if (t_now !== hms(0, 1, 0) || ring !== 1'b0) begin
            n_err++;
            $display("FAIL fire_disabled: got t=%h ring=%b required t=%h ring=0", t_now, ring,
                     hms(0, 1, 0));
        end
    endtask

    task automatic test_ring_cancel();
        alarm_en = 1'b1;
        edit_to(0, 0, 0, 59);
        do_tick();
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        n_vec++;
        if (ring !== 1'b0 || t_now !== hms(0, 1, 0)) begin
            n_err++;
            $display("FAIL cancel_inc: got ring=%b t=%h required ring=0 t=%h", ring, t_now,
                     hms(0, 1, 0));
        end
        // Alarm sec walks a full lap back to 00:01:00 = current time; no ring may result.
        m_alarm = 1'b1; inc_sec = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            n_vec++;
            if (ring !== 1'b0) begin
                n_err++;
                $display("FAIL cancel_edit_%0d: got ring=%b required 0", i, ring);
            end
        end
        inc_sec = 1'b0; m_alarm = 1'b0;
        n_vec++;
        if (a_now !== hms(0, 1, 0)) begin
            n_err++;
            $display("FAIL cancel_edit_alarm: got %h required %h", a_now, hms(0, 1, 0));
        end
        edit_to(0, 0, 0, 59);
        do_tick();
        alarm_en = 1'b0;
        step();
        n_vec++;
        if (ring !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_en_low: got ring=%b required 0", ring);
        end
        alarm_en = 1'b1;
        do_tick();
        n_vec++;
        if (ring !== 1'b0 || t_now !== hms(0, 1, 1)) begin
            n_err++;
            $display("FAIL cancel_stays: got ring=%b t=%h required ring=0 t=%h", ring, t_now,
                     hms(0, 1, 1));
        end
    endtask

    task automatic test_aset_tick_and_inc();
        m_alarm = 1'b1; tick = 1'b1; inc_hour = 1'b1;
        step();
        m_alarm = 1'b0; tick = 1'b0; inc_hour = 1'b0;
        n_vec++;
        if (t_now !== hms(0, 1, 2) || a_now !== hms(1, 1, 0)) begin
            n_err++;
            $display("FAIL aset_both: got t=%h a=%h required t=%h a=%h", t_now, a_now,
                     hms(0, 1, 2), hms(1, 1, 0));
        end
    endtask

    task automatic test_illegal_mode();
        m_load = 1'b1; m_alarm = 1'b1; tick = 1'b1; inc_hour = 1'b1;
        step();
        m_load = 1'b0; m_alarm = 1'b0; tick = 1'b0; inc_hour = 1'b0;
        n_vec++;
        if (t_now !== hms(0, 1, 3) || a_now !== hms(1, 1, 0)) begin
            n_err++;
            $display("FAIL illegal_mode: got t=%h a=%h required t=%h a=%h", t_now, a_now,
                     hms(0, 1, 3), hms(1, 1, 0));
        end
    endtask

    task automatic test_mid_ring_reset();
        edit_to(1, 0, 1, 4);
        alarm_en = 1'b1;
        do_tick();
        n_vec++;
        if (ring !== 1'b1) begin
            n_err++;
            $display("FAIL midring_fire: got ring=%b required 1", ring);
        end
        m_reset = 1'b1;
        step();
        m_reset = 1'b0;
        n_vec++;
        if (ring !== 1'b0 || t_now !== 17'h0 || a_now !== 17'h0) begin
            n_err++;
            $display("FAIL midring_reset: got ring=%b t=%h a=%h required 0/0/0", ring, t_now,
                     a_now);
        end
        do_tick();
        n_vec++;
        if (ring !== 1'b0 || t_now !== hms(0, 0, 1)) begin
            n_err++;
            $display("FAIL midring_after: got ring=%b t=%h required ring=0 t=%h", ring, t_now,
                     hms(0, 0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_load_isolation();
        test_clock_ignores_inc();
        test_alarm_fire();
        test_ring_cancel();
        test_aset_tick_and_inc();
        test_illegal_mode();
        test_mid_ring_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_timekeeper.md
CLOCK_TIMEKEEPER -- requirements
Module: clock_timekeeper

Interface
REQ-001 SHALL have parameter RING_LEN, default 30: number of tick pulses the alarm output stays asserted after a match.
REQ-002 SHALL have port m_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port m_reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port tick, input, 1 bit: 1 Hz time-base enable, one m_clk cycle wide.
REQ-005 SHALL have port m_load, input, 1 bit: mode select from the mode FSM; high selects time-load mode.
REQ-006 SHALL have port m_alarm, input, 1 bit: mode select from the mode FSM; high selects alarm-set mode.
REQ-007 SHALL have ports inc_sec, inc_min, inc_hour, input, 1 bit each: single-cycle field-increment pulses (debounced buttons).
REQ-008 SHALL have port alarm_en, input, 1 bit: alarm arm switch.
REQ-009 SHALL have ports sec, min, output, 6 bits each, and hour, output, 5 bits: current time, binary.
REQ-010 SHALL have ports al_sec, al_min, output, 6 bits each, and al_hour, output, 5 bits: alarm time, binary.
REQ-011 SHALL have port ring, output, 1 bit: alarm sounding.

Function
REQ-012 SHALL decode modes as: clock = m_load 0 and m_alarm 0; load = m_load 1 and m_alarm 0; alarm-set = m_alarm 1 and m_load 0; both high SHALL be treated as clock mode.
REQ-013 SHALL, in clock and alarm-set modes, advance time by one second per tick: sec 59->0 with carry to min; min 59->0 with carry to hour; hour 23->0; the update is visible the cycle after tick.
REQ-014 SHALL, in load mode, ignore tick (time frozen).
REQ-015 SHALL, in load mode, increment sec modulo 60, min modulo 60, hour modulo 24 on the respective inc_* pulse, with no carry between fields.
REQ-016 SHALL, in alarm-set mode, apply the same modulo increments to al_sec, al_min, al_hour, while time continues to advance on tick.
REQ-017 SHALL ignore inc_* for field editing in clock mode.
REQ-018 SHALL apply simultaneous inc_* pulses independently in the same cycle.
REQ-019 SHALL apply a tick and inc_* pulse in the same cycle in alarm-set mode both: time advances and the alarm field increments.
REQ-020 SHALL detect a match only on a tick that advances time, and only when the new time equals {al_hour, al_min, al_sec} and alarm_en=1.
REQ-021 SHALL NOT detect a match from editing alarm or time fields.
REQ-022 SHALL, on a match, assert ring the cycle after the tick and load a ring counter with RING_LEN.
REQ-023 SHALL, while ring=1, decrement the ring counter on each subsequent tick in any mode, and deassert ring on the tick that decrements it to 0; the match tick itself is not counted.
REQ-024 SHALL clear ring and the ring counter the cycle after any inc_* pulse (any mode) or after alarm_en goes low.
REQ-025 SHALL restart the ring count at RING_LEN if a new match occurs while ringing.
REQ-026 SHALL keep all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, when m_reset=1 at a rising edge, set sec, min, hour, al_sec, al_min, al_hour to 0, ring to 0, and the ring counter to 0, overriding all other inputs that cycle.
REQ-028 SHALL, on reset mid-ring or mid-edit, discard the operation entirely; no partial state survives.

Verification
REQ-029 SHALL verify reset: assert m_reset with tick and inc_* active -> next cycle all time and alarm fields 0, ring 0.
REQ-030 SHALL verify rollover: load mode, set 23:59:58, then clock mode with 3 ticks -> 23:59:59, 00:00:00, 00:00:01.
REQ-031 SHALL verify load-mode isolation: load mode, sec=59, inc_sec plus tick in the same cycle -> sec 0, min and hour unchanged, tick has no effect.
REQ-032 SHALL verify alarm firing: alarm 00:01:00, time 00:00:59, alarm_en=1, one tick -> time 00:01:00 and ring=1 the next cycle; ring stays high for exactly 30 further ticks, then 0.
REQ-033 SHALL verify ring cancel: while ringing, pulse inc_min in clock mode -> ring 0 next cycle and min unchanged; in alarm-set mode, editing the alarm to equal the current time -> ring stays 0.
REQ-034 SHALL verify illegal mode: m_load=1 and m_alarm=1, tick plus inc_hour -> time advances one second, hour and alarm fields not edited.
